pipe_stage_elastic: RTL and testbench
=====================================

Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers (IF/ID, ID/EXE, EXE/MEM, MEM/WB).
- Adds a valid/ready handshake with a 2-entry skid buffer, so back-pressure from a later stage never drops or duplicates an instruction.
- Keeps the existing flush/freez semantics.
- Control bits (wb_en, mem_read, mem_write, branch_type, exe_cmd, ...) travel separately from payload (pc, instruction, operands, dest) so bubbles are guaranteed side-effect free.
- Includes a saturating stall counter for performance debug.

Parameters:
- CTRL_W, 10, width of the control bundle; forced to zero on the output whenever no valid instruction is presented.
- DATA_W, 138, width of the payload bundle (pc 32 + instruction 32 + reg2 32 + alu_inp1/2 trimmed, etc.); never gated.
- CNT_W, 16, width of the stall counter.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  stage presents an instruction downstream
- out_ready  in  1  downstream accepts
- out_ctrl  out  CTRL_W  control bundle; zero when out_valid=0
- out_data  out  DATA_W  payload; don't-care when out_valid=0
- flush  in  1  synchronous kill of all held instructions
- freez  in  1  hold state; no transfers on either side
- occupancy  out  2  number of held entries (0..2)
- stall_count  out  CNT_W  cycles with a held entry blocked by out_ready=0

Behaviour:
- Storage: main entry (valid, ctrl, data) drives the outputs; skid entry (valid, ctrl, data) absorbs one extra instruction.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = !flush & !freez & !skid_valid. It depends only on state plus flush/freez, never on in_valid or out_ready.
- out_valid = main_valid & !flush & !freez.
- out_ctrl = out_valid ? main_ctrl : 0. out_data = main_data (ungated).
- State machine, encoded by occupancy:
  - EMPTY (0):
    - in_fire -> main<=in; go to ONE.
  - ONE (1):
    - in_fire & out_fire -> main<=in; stay ONE.
    - in_fire & !out_fire -> skid<=in; go to FULL.
    - !in_fire & out_fire -> go to EMPTY.
    - Neither -> hold.
  - FULL (2), in_ready=0:
    - out_fire -> main<=skid, skid_valid<=0; go to ONE.
    - Otherwise hold.
- Ordering: the instruction in main always precedes the one in skid. Output order equals input order; no loss, no duplication.
- Latency: 1 cycle from in_fire to out_valid when EMPTY. Full throughput (1 per cycle) when out_ready stays high.
- freez=1:
  - in_ready=0 and out_valid=0.
  - All state and stall_count are held.
  - Matches the legacy freeze.
- flush=1:
  - Next edge clears main_valid and skid_valid -> EMPTY.
  - The input in the same cycle is discarded (in_ready=0); no transfer occurs.
  - Data registers hold their contents.
  - flush has priority over freez.
- Reset (reset=0, asynchronous):
  - All valids 0, ctrl and data registers 0.
  - occupancy=0, stall_count=0.
  - Therefore out_valid=0, out_ctrl=0, and in_ready=1 immediately after release (flush=freez=0).
  - Reset mid-transfer discards both entries.
- stall_count:
  - Increments when main_valid & !out_ready & !freez & !flush.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset.
- occupancy = main_valid + skid_valid. Invariant: skid_valid implies main_valid.

Test Plan:
- Reset release with in_valid=1, in_ctrl=0x3FF, in_data=A, out_ready=1 -> out_valid=1, out_ctrl=0x3FF, out_data=A on the next cycle; occupancy=1.
- Stream of 8 instructions (data 1..8), out_ready=1 throughout -> outputs 1..8 on consecutive cycles; in_ready never 0; stall_count=0.
- out_ready=0 while sending A, B, C:
  - A is taken into main, B into skid; occupancy=2, in_ready=0, so C waits.
  - Raise out_ready -> outputs A, B, C in order; stall_count=2.
- FULL state (A, B held), pulse flush one cycle with in_valid=1, data=D:
  - Next cycle occupancy=0, out_valid=0, out_ctrl=0; D is not captured.
- freez=1 for 3 cycles while holding A with out_ready=1 -> out_valid=0, in_ready=0, stall_count unchanged; after release A appears once.
- CNT_W=3, out_ready=0 for 10 cycles with one entry held -> stall_count saturates at 7.
- Assert reset mid-stream with occupancy=2 -> all outputs zero and occupancy=0 asynchronously, before the next edge.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage pipeline register: valid/ready handshake with a 2-entry skid buffer,
// legacy flush/freez semantics, gated control bundle and a saturating stall counter.
module pipe_stage_elastic #(
  parameter int unsigned CTRL_W = 10,
  parameter int unsigned DATA_W = 138,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              freez,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic main_valid;
  logic skid_valid;
  logic in_fire;
  logic out_fire;
  logic stall_inc;

  // Occupancy is the state encoding; main is always filled before skid.
  assign main_valid = (state_q == ONE) || (state_q == FULL);
  assign skid_valid = (state_q == FULL);

  assign in_ready  = !flush && !freez && !skid_valid;
  assign out_valid = main_valid && !flush && !freez;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  assign out_ctrl    = out_valid ? main_ctrl_q : '0;
  assign out_data    = main_data_q;
  assign occupancy   = 2'(main_valid) + 2'(skid_valid);
  assign stall_count = stall_q;

  assign stall_inc = main_valid && !out_ready && !freez && !flush;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    stall_d     = stall_q;

    if (stall_inc && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end

    // Flush only drops the valids; payload registers keep their contents.
    if (flush) begin
      state_d = EMPTY;
    end else if (!freez) begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            state_d     = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (in_fire) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            state_d     = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            state_d     = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      stall_q     <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic: directed stimulus pushes expected outputs,
// a negedge monitor pops and compares whenever the stage transfers downstream.
module tb_pipe_stage_elastic;

  localparam int unsigned CW = 10;
  localparam int unsigned DW = 138;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } exp_t;

  logic          clock;
  logic          reset;
  logic          in_valid, in_ready, out_valid, out_ready, flush, freez;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occupancy;
  logic [15:0]   stall_count;

  logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [CW-1:0] s_in_ctrl, s_out_ctrl;
  logic [DW-1:0] s_in_data, s_out_data;
  logic [1:0]    s_occupancy;
  logic [2:0]    s_stall_count;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(16)) u_dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .flush(flush), .freez(freez), .occupancy(occupancy), .stall_count(stall_count)
  );

  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(3)) u_sat (
    .clock(clock), .reset(reset),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_ctrl(s_in_ctrl), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
    .flush(1'b0), .freez(1'b0), .occupancy(s_occupancy), .stall_count(s_stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [DW-1:0] mk_data(input int id);
    logic [DW-1:0] d;
    d          = '0;
    d[31:0]    = 32'(id) | 32'hD000_0000;
    d[137:106] = 32'(id) ^ 32'h5A5A_5A5A;
    return d;
  endfunction

  function automatic logic [CW-1:0] mk_ctrl(input int id);
    return CW'(id * 37 + 5);
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Offer one instruction and hold it until the stage accepts it.
  task automatic send(input logic [CW-1:0] c, input logic [DW-1:0] d);
    bit accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = d;
    for (int t = 0; t < 20 && !accepted; t++) begin
      @(negedge clock);
      if (in_ready) begin
        sb_q.push_back('{c: c, d: d});
        accepted = 1'b1;
      end
      @(posedge clock);
      #1;
    end
    if (!accepted) begin
      checks++;
      failures++;
      $display("FAIL send_timeout data=%0h not accepted within 20 cycles", d);
    end
    in_valid = 1'b0;
  endtask

  always @(negedge clock) begin
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%0h expected=none", out_data);
      end else begin
        mon_e = sb_q.pop_front();
        chk("out_ctrl", DW'(out_ctrl), DW'(mon_e.c));
        chk("out_data", out_data, mon_e.d);
      end
    end else if (!out_valid) begin
      chk("idle_ctrl_zero", DW'(out_ctrl), '0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b0;
    in_valid    = 1'b1;
    in_ctrl     = 10'h3FF;
    in_data     = mk_data(100);
    out_ready   = 1'b1;
    flush       = 1'b0;
    freez       = 1'b0;
    s_in_valid  = 1'b0;
    s_in_ctrl   = '0;
    s_in_data   = '0;
    s_out_ready = 1'b1;

    #2;
    chkn("rst_out_valid", int'(out_valid), 0);
    chkn("rst_out_ctrl", int'(out_ctrl), 0);
    chkn("rst_occupancy", int'(occupancy), 0);
    chkn("rst_stall", int'(stall_count), 0);
    chkn("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_data", out_data, '0);

    // Reset release with an instruction already offered: one-cycle latency.
    @(posedge clock);
    #1;
    reset = 1'b1;
    send(10'h3FF, mk_data(100));
    @(negedge clock);
    chkn("t1_occupancy", int'(occupancy), 1);
    chkn("t1_out_valid", int'(out_valid), 1);
    chkn("t1_out_ctrl", int'(out_ctrl), 10'h3FF);
    tick(2);
    chkn("t1_drained", sb_q.size(), 0);

    // Back-to-back stream at full throughput.
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_ctrl  = mk_ctrl(i);
      in_data  = mk_data(i);
      @(negedge clock);
      chkn("stream_in_ready", int'(in_ready), 1);
      chkn("stream_out_valid", int'(out_valid), (i > 1) ? 1 : 0);
      if (in_ready) sb_q.push_back('{c: mk_ctrl(i), d: mk_data(i)});
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    tick(3);
    chkn("stream_drained", sb_q.size(), 0);
    chkn("stream_stall", int'(stall_count), 0);

    // Back-pressure: A in main, B in skid, C waits.
    out_ready = 1'b0;
    send(mk_ctrl(11), mk_data(11));
    send(mk_ctrl(12), mk_data(12));
    in_valid = 1'b1;
    in_ctrl  = mk_ctrl(13);
    in_data  = mk_data(13);
    @(negedge clock);
    chkn("bp_occupancy", int'(occupancy), 2);
    chkn("bp_in_ready", int'(in_ready), 0);
    chkn("bp_out_valid", int'(out_valid), 1);
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    send(mk_ctrl(13), mk_data(13));
    tick(3);
    chkn("bp_drained", sb_q.size(), 0);
    chkn("bp_stall", int'(stall_count), 2);

    // Flush while FULL, with D offered in the same cycle.
    out_ready = 1'b0;
    send(mk_ctrl(21), mk_data(21));
    send(mk_ctrl(22), mk_data(22));
    in_valid = 1'b1;
    in_ctrl  = mk_ctrl(23);
    in_data  = mk_data(23);
    flush    = 1'b1;
    @(negedge clock);
    chkn("flush_in_ready", int'(in_ready), 0);
    chkn("flush_out_valid", int'(out_valid), 0);
    @(posedge clock);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    sb_q.delete();
    @(negedge clock);
    chkn("flush_occupancy", int'(occupancy), 0);
    chkn("flush_out_valid_after", int'(out_valid), 0);
    chkn("flush_out_ctrl", int'(out_ctrl), 0);
    chkn("flush_in_ready_after", int'(in_ready), 1);
    out_ready = 1'b1;
    tick(3);
    chkn("flush_stall", int'(stall_count), 3);

    // Freeze for three cycles while holding A; junk offered meanwhile.
    send(mk_ctrl(31), mk_data(31));
    freez = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) out_ready = 1'b0;
      in_valid = 1'b1;
      in_ctrl  = mk_ctrl(99);
      in_data  = mk_data(99);
      @(negedge clock);
      chkn("frz_out_valid", int'(out_valid), 0);
      chkn("frz_in_ready", int'(in_ready), 0);
      chkn("frz_occupancy", int'(occupancy), 1);
      @(posedge clock);
      #1;
    end
    freez     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chkn("frz_stall", int'(stall_count), 3);
    tick(3);
    chkn("frz_drained", sb_q.size(), 0);
    chkn("frz_occupancy_after", int'(occupancy), 0);

    // Asynchronous reset while FULL.
    out_ready = 1'b0;
    send(mk_ctrl(41), mk_data(41));
    send(mk_ctrl(42), mk_data(42));
    @(negedge clock);
    chkn("pre_rst_occupancy", int'(occupancy), 2);
    chkn("pre_rst_stall", int'(stall_count), 4);
    #2;
    reset = 1'b0;
    #1;
    chkn("arst_occupancy", int'(occupancy), 0);
    chkn("arst_out_valid", int'(out_valid), 0);
    chkn("arst_out_ctrl", int'(out_ctrl), 0);
    chkn("arst_stall", int'(stall_count), 0);
    chkn("arst_in_ready", int'(in_ready), 1);
    sb_q.delete();
    @(posedge clock);
    #1;
    reset     = 1'b1;
    out_ready = 1'b1;
    tick(3);
    chkn("post_rst_occupancy", int'(occupancy), 0);

    // Saturating stall counter on the CNT_W=3 instance.
    s_out_ready = 1'b0;
    s_in_valid  = 1'b1;
    s_in_ctrl   = mk_ctrl(77);
    s_in_data   = mk_data(77);
    tick(1);
    s_in_valid = 1'b0;
    chkn("sat_occupancy", int'(s_occupancy), 1);
    tick(6);
    chkn("sat_stall_6", int'(s_stall_count), 6);
    tick(4);
    chkn("sat_stall_7", int'(s_stall_count), 7);
    chkn("sat_out_valid", int'(s_out_valid), 1);
    chk("sat_out_data", s_out_data, mk_data(77));

    chkn("final_sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
